// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, start bit, 8 data bits LSB first,
// odd parity, stop bit, then device acknowledge. Open-drain lines driven only to 0 or Z.
module ps2_tx #(
    parameter int RTS_CYCLES     = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam int MAX_CYCLES = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] RTS_LOAD = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RTS,
        S_START,
        S_DATA,
        S_STOP,
        S_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    filter_q, filter_d;
    logic          fclk_q, fclk_d;
    logic [1:0]    dsync_q, dsync_d;
    logic [8:0]    shift_q, shift_d;
    logic [3:0]    n_q, n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fall_edge;
    logic          c_drive;
    logic          d_drive;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            filter_q <= 8'hFF;
            fclk_q   <= 1'b1;
            dsync_q  <= 2'b11;
            shift_q  <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            filter_q <= filter_d;
            fclk_q   <= fclk_d;
            dsync_q  <= dsync_d;
            shift_q  <= shift_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Clock changes only after eight identical samples, so short glitches never make an edge.
    always_comb begin
        filter_d = {ps2c, filter_q[7:1]};
        fclk_d   = fclk_q;
        if (filter_d == 8'hFF) begin
            fclk_d = 1'b1;
        end else if (filter_d == 8'h00) begin
            fclk_d = 1'b0;
        end
        fall_edge = fclk_q & ~fclk_d;
        dsync_d   = {dsync_q[0], ps2d};
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        c_drive = 1'b0;
        d_drive = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_ps2) begin
                    shift_d = {~^din, din};
                    cnt_d   = RTS_LOAD;
                    state_d = S_RTS;
                end
            end
            S_RTS: begin
                c_drive = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = TO_LOAD;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_START: begin
                d_drive = 1'b1;
                if (fall_edge) begin
                    n_d     = 4'd8;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                d_drive = ~shift_q[0];
                if (fall_edge) begin
                    shift_d = {1'b0, shift_q[8:1]};
                    if (n_q == 4'd0) begin
                        state_d = S_STOP;
                    end else begin
                        n_d = n_q - 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (fall_edge) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (fall_edge) begin
                    done_d  = ~dsync_q[1];
                    err_d   = dsync_q[1];
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Once the device owns the clock, every falling edge restarts the stall watchdog.
        if (state_q inside {S_START, S_DATA, S_STOP, S_ACK}) begin
            if (fall_edge) begin
                cnt_d = TO_LOAD;
            end else if (cnt_q == '0) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    assign ps2c         = c_drive ? 1'b0 : 1'bz;
    assign ps2d         = d_drive ? 1'b0 : 1'bz;
    assign tx_idle      = (state_q == S_IDLE);
    assign tx_done_tick = done_q;
    assign tx_err_tick  = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: a behavioural PS/2 device clocks the frame out,
// and each sampled frame is compared with one built from the byte by plain arithmetic.
module tb_ps2_tx;

    localparam int RTS = 200;
    localparam int TO  = 500;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err_tick;

    bit devClkLow  = 1'b0;
    bit devDataLow = 1'b0;
    int vectors     = 0;
    int miscompares = 0;
    int doneSeen    = 0;
    int errSeen     = 0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = devClkLow  ? 1'b0 : 1'bz;
    assign ps2d = devDataLow ? 1'b0 : 1'bz;

    ps2_tx #(
        .RTS_CYCLES    (RTS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err_tick (tx_err_tick)
    );

    always #5 clk = ~clk;

    // Running tick totals let each send confirm exactly how many ticks it produced.
    always @(negedge clk) begin
        if (tx_done_tick) doneSeen++;
        if (tx_err_tick) errSeen++;
    end

    initial begin
        #900_000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] aborting");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe a byte at a negedge, then measure how long the host holds the clock low.
    task automatic applyStimulus(input logic [7:0] b);
        int lowCycles;
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        checkOutput("idle_low", tx_idle, 0);
        lowCycles = 0;
        while (ps2c === 1'b0 && lowCycles < 4 * RTS) begin
            lowCycles++;
            @(negedge clk);
        end
        checkOutput("rts_len", lowCycles, RTS);
        checkOutput("start_clk", ps2c, 1);
        checkOutput("start_data", ps2d, 0);
    endtask

    task automatic runSend(input logic [7:0] b, input int h, input bit nack,
                           input bit glitch, input bit busy, input bit resetMid);
        logic [10:0] frame;
        logic [10:0] expFrame;
        int d0;
        int e0;
        bit par;
        bit seen;
        d0       = doneSeen;
        e0       = errSeen;
        par      = ($countones(b) % 2 == 0);
        expFrame = 11'(1024 + (par ? 512 : 0) + int'(b) * 2);
        applyStimulus(b);
        if (glitch) begin
            repeat (12) @(negedge clk);
            devClkLow = 1'b1;
            repeat (5) @(negedge clk);
            devClkLow = 1'b0;
            repeat (10) @(negedge clk);
            checkOutput("glitch_hold", ps2d, 0);
        end
        repeat (h) @(negedge clk);
        frame[0] = ps2d;
        for (int i = 1; i <= 10; i++) begin
            devClkLow = 1'b1;
            repeat (h) @(negedge clk);
            devClkLow = 1'b0;
            frame[i] = ps2d;
            if (resetMid && i == 4) begin
                checkOutput("pre_reset_data", ps2d, 0);
                reset = 1'b1;
                #1;
                checkOutput("rst_clk_rel", ps2c, 1);
                checkOutput("rst_data_rel", ps2d, 1);
                checkOutput("rst_idle", tx_idle, 1);
                @(negedge clk);
                reset = 1'b0;
                repeat (2 * h) @(negedge clk);
                checkOutput("rst_no_done", doneSeen - d0, 0);
                checkOutput("rst_no_err", errSeen - e0, 0);
                checkOutput("rst_idle_after", tx_idle, 1);
                return;
            end
            if (busy && i == 4) begin
                din    = 8'h12;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
                repeat (h - 1) @(negedge clk);
            end else begin
                repeat (h) @(negedge clk);
            end
        end
        checkOutput("frame", frame, expFrame);
        checkOutput("parity", frame[9], par);
        if (!nack) devDataLow = 1'b1;
        devClkLow = 1'b1;
        repeat (h) @(negedge clk);
        devClkLow = 1'b0;
        repeat (h) @(negedge clk);
        devClkLow = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < h + 20 && !seen; j++) begin
            @(negedge clk);
            if (tx_done_tick || tx_err_tick) seen = 1'b1;
        end
        checkOutput("tick_seen", seen, 1);
        if (seen) begin
            checkOutput("done_tick", tx_done_tick, !nack);
            checkOutput("err_tick", tx_err_tick, nack);
            checkOutput("idle_at_tick", tx_idle, 1);
        end
        devClkLow  = 1'b0;
        devDataLow = 1'b0;
        @(negedge clk);
        checkOutput("tick_width", {tx_done_tick, tx_err_tick}, 0);
        checkOutput("done_count", doneSeen - d0, !nack);
        checkOutput("err_count", errSeen - e0, nack);
        checkOutput("clk_released", ps2c, 1);
        checkOutput("data_released", ps2d, 1);
    endtask

    initial begin
        int n;
        logic [7:0] rb;
        reset  = 1'b1;
        wr_ps2 = 1'b0;
        din    = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_idle", tx_idle, 1);
        checkOutput("reset_done", tx_done_tick, 0);
        checkOutput("reset_err", tx_err_tick, 0);
        checkOutput("reset_clk", ps2c, 1);
        checkOutput("reset_data", ps2d, 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        runSend(8'hED, 40, 1'b0, 1'b1, 1'b0, 1'b0);
        runSend(8'h00, 40, 1'b0, 1'b0, 1'b0, 1'b0);
        runSend(8'hFF, 40, 1'b0, 1'b0, 1'b0, 1'b0);
        runSend(8'h5A, 35, 1'b1, 1'b0, 1'b0, 1'b0);
        runSend(8'h3C, 45, 1'b0, 1'b0, 1'b1, 1'b0);

        n = errSeen;
        applyStimulus(8'hA5);
        begin
            int c;
            c = 0;
            while (tx_err_tick !== 1'b1 && c < 2 * TO) begin
                @(negedge clk);
                c++;
            end
            checkOutput("timeout_len", c, TO);
        end
        checkOutput("timeout_no_done", tx_done_tick, 0);
        checkOutput("timeout_idle", tx_idle, 1);
        checkOutput("timeout_clk", ps2c, 1);
        checkOutput("timeout_data", ps2d, 1);
        @(negedge clk);
        checkOutput("timeout_err_count", errSeen - n, 1);

        runSend(8'hE5, 40, 1'b0, 1'b0, 1'b0, 1'b1);
        runSend(8'hF4, 40, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rb = 8'($urandom_range(0, 255));
            runSend(rb, int'($urandom_range(30, 60)), ($urandom_range(0, 3) == 0),
                    1'b0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
